// File: rtl/tx_pkg.sv
// Purpose: shared types and constants for the transmit-side block path.
//   TX_BLOCK_BITS  : width of one tx_fifo entry.
//   tx_ser_state_t : controller states of tx_block_serializer.
package tx_pkg;

  localparam int TX_BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SEND
  } tx_ser_state_t;

endpackage

// File: rtl/tx_block_serializer.sv
// Purpose: read-side controller of the 128-bit tx FIFO. Pops one block at a
// time and streams it out as WORD_BITS-wide words, most significant word
// first, on a valid/ready interface.
//
// Ports:
//   clk              in   system clock, rising edge
//   n_rst            in   asynchronous active-low reset
//   enable           in   permit starting new blocks (sampled in IDLE / block end)
//   fifo_empty       in   tx FIFO empty flag
//   fifo_read_data   in   FIFO head entry (combinational)
//   fifo_read_enable out  pop request; the FIFO pops on its rising edge
//   tx_valid         out  tx_data holds a valid word
//   tx_ready         in   downstream accepts the word
//   tx_data          out  current word
//   tx_last          out  current word is the last of its block
//   busy             out  controller not idle
//   block_count      out  blocks fully sent, wraps modulo 2^CNT_BITS
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for enable && !fifo_empty
// POP   | one-cycle fifo_read_enable pulse; head already captured
// SEND  | presenting words; leaves on the tx_last handshake
module tx_block_serializer
  import tx_pkg::*;
#(
  parameter int WORD_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [TX_BLOCK_BITS-1:0] fifo_read_data,
  output logic                     fifo_read_enable,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [WORD_BITS-1:0]     tx_data,
  output logic                     tx_last,
  output logic                     busy,
  output logic [CNT_BITS-1:0]      block_count
);

  localparam int WPB      = TX_BLOCK_BITS / WORD_BITS;
  localparam int IDX_BITS = (WPB > 2) ? $clog2(WPB) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WPB - 1);

  tx_ser_state_t            state_q, state_d;
  logic [TX_BLOCK_BITS-1:0] shift_q, shift_d;
  logic [IDX_BITS-1:0]      idx_q, idx_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;
  logic                     start_ok;
  logic                     last_word;

  assign start_ok  = enable && !fifo_empty;
  assign last_word = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // The head is captured in the cycle before the pop pulse, so the FIFO
  // pointer moving on the pulse never races the data we keep.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          shift_d = fifo_read_data;
          idx_d   = '0;
          state_d = POP;
        end
      end
      POP: begin
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          shift_d = shift_q << WORD_BITS;
          idx_d   = idx_q + 1'b1;
          if (last_word) begin
            cnt_d = cnt_q + 1'b1;
            // fifo_empty here already reflects the previous pop edge.
            if (start_ok) begin
              shift_d = fifo_read_data;
              idx_d   = '0;
              state_d = POP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode registered state only; tx_ready never reaches tx_valid.
  assign fifo_read_enable = (state_q == POP);
  assign tx_valid         = (state_q == SEND);
  assign tx_data          = shift_q[TX_BLOCK_BITS-1 -: WORD_BITS];
  assign tx_last          = (state_q == SEND) && last_word;
  assign busy             = (state_q != IDLE);
  assign block_count      = cnt_q;

endmodule

// File: tb/tb_tx_block_serializer.sv
module tb_tx_block_serializer;

  localparam int WPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT A: 32-bit words, 16-bit counter ----------------
  logic         n_rst, enable, tx_ready;
  logic         fifo_empty;
  logic [127:0] fifo_read_data;
  logic         fifo_read_enable, tx_valid, tx_last, busy;
  logic [31:0]  tx_data;
  logic [15:0]  block_count;

  logic [127:0] fmem [64];
  int unsigned  wr_ptr = 0;
  int unsigned  rd_ptr = 0;
  logic         pop_empty_err = 1'b0;

  assign fifo_empty     = (rd_ptr == wr_ptr);
  assign fifo_read_data = fifo_empty ? '0 : fmem[rd_ptr[5:0]];

  always @(posedge fifo_read_enable) begin
    if (rd_ptr == wr_ptr) pop_empty_err = 1'b1;
    else rd_ptr++;
  end

  task automatic push(input logic [127:0] d);
    fmem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  tx_block_serializer #(.WORD_BITS(32), .CNT_BITS(16)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read_enable(fifo_read_enable),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .busy(busy), .block_count(block_count)
  );

  // ---------------- DUT B: 64-bit words, 2-bit counter ----------------
  logic         b_enable, b_ready;
  logic         b_empty;
  logic [127:0] b_fdata;
  logic         b_re, b_valid, b_last, b_busy;
  logic [63:0]  b_data;
  logic [1:0]   b_count;
  logic [127:0] bmem [8];
  int unsigned  b_wr = 0;
  int unsigned  b_rd = 0;

  assign b_empty = (b_rd == b_wr);
  assign b_fdata = b_empty ? '0 : bmem[b_rd[2:0]];
  always @(posedge b_re) if (b_rd != b_wr) b_rd++;

  tx_block_serializer #(.WORD_BITS(64), .CNT_BITS(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .enable(b_enable), .fifo_empty(b_empty),
    .fifo_read_data(b_fdata), .fifo_read_enable(b_re),
    .tx_valid(b_valid), .tx_ready(b_ready), .tx_data(b_data),
    .tx_last(b_last), .busy(b_busy), .block_count(b_count)
  );

  // ---------------- behavioural model + per-cycle compare (DUT A) ----------------
  typedef struct packed { logic [31:0] d; logic l; } word_t;
  word_t        exp_q[$];
  word_t        w_m;
  int unsigned  exp_cnt = 0;
  logic         start_m;
  logic         p_rst = 1'b1;
  logic         p_en, p_empty, p_busy, p_valid, p_ready, p_last, p_re;
  logic [31:0]  p_data;
  logic [127:0] p_head;

  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete();
      exp_cnt = 0;
      p_rst   = 1'b1;
      check("rst_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_read_enable", fifo_read_enable, 0);
      check("rst_last", tx_last, 0);
      check("rst_count", block_count, 0);
    end else begin
      if (!p_rst) begin
        // A pop follows any edge where a new block may start.
        start_m = p_en && !p_empty && (!p_busy || (p_valid && p_ready && p_last));
        check("read_enable", fifo_read_enable, start_m);
        if (p_valid && p_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (p_last) begin
            exp_cnt++;
            if (!start_m) check("idle_after_block", busy, 0);
          end
        end
        if (p_re) check("send_after_pop", tx_valid, 1);
        if (p_valid && !p_ready) begin
          check("stall_valid", tx_valid, 1);
          check("stall_data", tx_data, p_data);
          check("stall_last", tx_last, p_last);
        end
      end
      if (fifo_read_enable) begin
        for (int i = 0; i < WPB; i++) begin
          w_m.d = p_head[127 - 32*i -: 32];
          w_m.l = (i == WPB - 1);
          exp_q.push_back(w_m);
        end
      end
      if (tx_valid) begin
        if (exp_q.size() == 0) check("unexpected_word", tx_valid, 0);
        else begin
          check("word_data", tx_data, exp_q[0].d);
          check("word_last", tx_last, exp_q[0].l);
        end
      end
      check("busy", busy, tx_valid | fifo_read_enable);
      check("block_count", block_count, exp_cnt[15:0]);
      check("pop_when_empty", pop_empty_err, 0);
      p_rst = 1'b0;
    end
    p_en    = enable;
    p_empty = fifo_empty;
    p_busy  = busy;
    p_valid = tx_valid;
    p_ready = tx_ready;
    p_last  = tx_last;
    p_re    = fifo_read_enable;
    p_data  = tx_data;
    p_head  = fifo_read_data;
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || (!fifo_empty && enable)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"timeout_", nm}, n < budget, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0]  w1 [4];
    logic [127:0] blk_r5 [2];
    logic [127:0] bblk [5];
    logic [1:0]   bcnt_exp [5];
    int           edges[$];
    int           sc, wi, bi, pushed, n;
    logic         pend, prev_re;

    w1 = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    bcnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    n_rst = 1'b0; enable = 1'b0; tx_ready = 1'b0;
    b_enable = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    check("reset_tx_data", tx_data, 0);
    check("reset_b_data", b_data, 0);
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;

    // Single block
    @(posedge clk); #1;
    push(128'h00112233_44556677_8899AABB_CCDDEEFF);
    enable = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    check("t1_cycle0_re", fifo_read_enable, 0);
    @(negedge clk);
    check("t1_cycle1_re", fifo_read_enable, 1);
    check("t1_cycle1_valid", tx_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid", tx_valid, 1);
      check("t1_word", tx_data, w1[i]);
      check("t1_last", tx_last, (i == 3));
    end
    @(negedge clk);
    check("t1_re_after", fifo_read_enable, 0);
    check("t1_idle", busy, 0);
    check("t1_count", block_count, 1);
    @(posedge clk); #1;
    enable = 1'b0;

    // Back-to-back, 3 blocks
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push({$urandom, $urandom, $urandom, $urandom});
    enable = 1'b1;
    prev_re = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_read_enable && !prev_re) edges.push_back(c);
      prev_re = fifo_read_enable;
    end
    check("t2_edges", edges.size(), 3);
    if (edges.size() == 3) begin
      check("t2_first_pop", edges[0], 1);
      check("t2_gap1", edges[1] - edges[0], 5);
      check("t2_gap2", edges[2] - edges[1], 5);
    end
    check("t2_count", block_count, 4);
    check("t2_fifo_empty", fifo_empty, 1);
    @(posedge clk); #1;
    enable = 1'b0;

    // Backpressure: ready alternates starting at 0
    @(posedge clk); #1;
    push({$urandom, $urandom, $urandom, $urandom});
    enable = 1'b1; tx_ready = 1'b0;
    sc = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (tx_valid) sc++;
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
      if (c == 2) enable = 1'b0;
    end
    check("t3_send_cycles", sc, 8);
    check("t3_count", block_count, 5);
    tx_ready = 1'b1;

    // Enable dropped mid-block
    @(posedge clk); #1;
    push({$urandom, $urandom, $urandom, $urandom});
    push({$urandom, $urandom, $urandom, $urandom});
    enable = 1'b1;
    sc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (tx_valid) sc++;
    end
    @(posedge clk); #1;
    enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (tx_valid) sc++;
    end
    check("t4_words", sc, 4);
    check("t4_idle", busy, 0);
    check("t4_fifo_left", wr_ptr - rd_ptr, 1);
    check("t4_count", block_count, 6);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_idle(40, "t4_drain");
    check("t4_count_drained", block_count, 7);
    @(posedge clk); #1;
    enable = 1'b0;

    // Reset mid-SEND
    @(posedge clk); #1;
    blk_r5[0] = {$urandom, $urandom, $urandom, $urandom};
    blk_r5[1] = {$urandom, $urandom, $urandom, $urandom};
    push(blk_r5[0]);
    push(blk_r5[1]);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1;
    check("t5_valid_async", tx_valid, 0);
    check("t5_busy_async", busy, 0);
    check("t5_re_async", fifo_read_enable, 0);
    check("t5_count_async", block_count, 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_restart_timeout", n < 20, 1);
    check("t5_restart_word0", tx_data, blk_r5[1][127:96]);
    wait_idle(40, "t5_drain");
    check("t5_count", block_count, 1);
    check("t5_fifo_empty", fifo_empty, 1);

    // Randomized traffic against the model
    pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      enable   = ($urandom_range(0, 3) != 0);
      tx_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 4) == 0 && (wr_ptr - rd_ptr) < 32) begin
        push({$urandom, $urandom, $urandom, $urandom});
        pushed++;
      end
    end
    @(posedge clk); #1;
    enable = 1'b1; tx_ready = 1'b1;
    wait_idle(400, "rand_drain");
    check("rand_fifo_empty", fifo_empty, 1);
    check("rand_count", block_count, 16'(1 + pushed));
    @(posedge clk); #1;
    enable = 1'b0;

    // Counter wrap on the 64-bit / 2-bit-counter instance
    for (int i = 0; i < 5; i++) begin
      bblk[i] = {$urandom, $urandom, $urandom, $urandom};
      bmem[b_wr[2:0]] = bblk[i];
      b_wr++;
    end
    b_enable = 1'b1; b_ready = 1'b1;
    wi = 0; bi = 0; pend = 1'b0; n = 0;
    while ((bi < 5 || pend) && n < 60) begin
      @(negedge clk);
      n++;
      if (pend) begin
        check("t6_count", b_count, bcnt_exp[bi-1]);
        pend = 1'b0;
      end
      if (b_valid && bi < 5) begin
        check("t6_word", b_data, (wi == 0) ? bblk[bi][127:64] : bblk[bi][63:0]);
        check("t6_last", b_last, (wi == 1));
        wi++;
        if (wi == 2) begin
          wi = 0;
          bi++;
          pend = 1'b1;
        end
      end
    end
    check("t6_timeout", n < 60, 1);
    @(negedge clk);
    check("t6_idle", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_block_serializer.md
# tx_block_serializer

Controller on the read side of the 128-bit transmit FIFO (`tx_fifo`). It pops one 128-bit block at a time and splits it into `WORD_BITS`-wide words, most significant word first. Words go out on a valid/ready stream to the downstream transmit interface. It generates the FIFO's edge-sensitive `read_enable` pulse, so every pop is one clean rising edge.

## Interface
- `WORD_BITS`, 32: output word width; legal values 8, 16, 32, 64; words per block `WPB = 128/WORD_BITS`.
- `CNT_BITS`, 16: width of the sent-block counter.
- `clk`  in  1: system clock, all logic on rising edge.
- `n_rst`  in  1: reset; one clock; reset is asynchronous and active-low.
- `enable`  in  1: permit starting new blocks; sampled only in IDLE and at block end.
- `fifo_empty`  in  1: from tx FIFO.
- `fifo_read_data`  in  128: FIFO head entry, combinational.
- `fifo_read_enable`  out  1: pop request to FIFO; FIFO pops on its rising edge.
- `tx_valid`  out  1: `tx_data` holds a valid word.
- `tx_ready`  in  1: downstream accepts word when `tx_valid && tx_ready`.
- `tx_data`  out  `WORD_BITS`: current word.
- `tx_last`  out  1: current word is the final word of its block.
- `busy`  out  1: state != IDLE.
- `block_count`  out  `CNT_BITS`: number of blocks fully sent, modulo 2^`CNT_BITS`.

## Operation
- State machine has three states: IDLE, POP, SEND.
- **IDLE**
  - If `enable && !fifo_empty`: load `fifo_read_data` into a 128-bit shift register, clear the word index, go to POP.
  - Otherwise stay in IDLE.
- **POP**
  - `fifo_read_enable = 1` for exactly this one cycle; it is a Moore output, `fifo_read_enable = (state == POP)`.
  - Unconditionally go to SEND.
- **SEND**
  - `tx_valid = 1`; `tx_data = shift_reg[127 -: WORD_BITS]`; `tx_last = (index == WPB-1)`.
  - On each handshake, shift the register left by `WORD_BITS` and increment the index.
  - On the handshake with `tx_last`:
    - `block_count` increments, wrapping from all-ones to 0.
    - If `enable && !fifo_empty`: load the new head and go to POP (back-to-back path).
    - Otherwise go to IDLE.
- Stall rule: while `tx_valid && !tx_ready`, `tx_data` and `tx_last` hold stable. `tx_valid` never drops before its handshake.
- Disabling mid-block: `enable` falling during SEND does not abort. The current block completes, then the controller goes to IDLE.
- Edge rule: `fifo_read_enable` is low in every cycle adjacent to a POP cycle, because SEND lasts at least 1 cycle (`WPB` ≥ 2). Each pop therefore produces a fresh rising edge.
- Empty FIFO: no pop is ever issued while `fifo_empty = 1`.
- The full flag is not used.
- Reset mid-operation:
  - All state returns to its reset value immediately.
  - A block that was already popped but only partly sent is discarded; it is not re-sent.

## Timing
- Reset values: state IDLE; `fifo_read_enable` 0; `tx_valid` 0; `tx_last` 0; `tx_data` 0; `busy` 0; `block_count` 0; shift register 0; index 0.
- Latency: `enable && !fifo_empty` true in cycle 0 (IDLE) gives POP in cycle 1 and first `tx_valid` in cycle 2.
- Throughput with `tx_ready` held high: `WPB + 1` cycles per block. That is `WPB` SEND cycles plus one POP cycle with `tx_valid` low.
- `fifo_empty` is re-evaluated in SEND, one cycle after the pop edge. The FIFO pointer has therefore settled.
- `block_count` updates on the clock edge that completes the `tx_last` handshake.
- All outputs are functions of registered state only; there is no combinational path from `tx_ready` to `tx_valid`.

## Structure
- Shared package `tx_pkg`:
  - `typedef enum logic [1:0] {IDLE, POP, SEND} tx_ser_state_t`.
  - Constant `TX_BLOCK_BITS = 128`.
- The derived constant `WPB` is computed locally from the parameter.
- Single module; no sub-module. The shift register, index counter and block counter are inline.
- Index width: `$clog2(WPB)`, minimum 1.

## Test plan
- **Single block, `WORD_BITS` = 32.**
  - Stimulus: FIFO holds `128'h00112233_44556677_8899AABB_CCDDEEFF`; `enable` = 1; `tx_ready` = 1.
  - Required: `fifo_read_enable` high for exactly 1 cycle (cycle 1).
  - Required: words `00112233`, `44556677`, `8899AABB`, `CCDDEEFF` in cycles 2–5; `tx_last` only on cycle 5.
  - Required: `block_count` = 1; then IDLE.
- **Back-to-back, 3 blocks queued.**
  - Required: exactly 3 rising edges on `fifo_read_enable`, separated by 5 cycles.
  - Required: 12 words in order; `block_count` = 3; `fifo_empty` = 1 at end; no 4th pop.
- **Backpressure.**
  - Stimulus: `tx_ready` alternates 0/1 starting at 0.
  - Required: each word is held stable until accepted; no word is dropped or duplicated; a block takes 8 SEND cycles.
- **Enable dropped mid-block.**
  - Stimulus: `enable` = 0 after the 2nd word, with 2 blocks queued.
  - Required: block 1 completes with 4 words; then IDLE; FIFO still holds 1 entry; `block_count` = 1.
- **Reset mid-SEND.**
  - Stimulus: assert `n_rst` low after word 2, asynchronously and between clock edges.
  - Required: `tx_valid`, `busy` and `fifo_read_enable` go to 0 immediately; `block_count` = 0.
  - Required: after release, the next queued block is sent from word 0.
- **Counter wrap, `CNT_BITS` = 2, `WORD_BITS` = 64.**
  - Stimulus: send 5 blocks.
  - Required: `block_count` reads 1, 2, 3, 0, 1; each block is 2 words.
